// File: rtl/servo_pkg.sv
// Shared types and constants for the IR servo scan sequencer and its PWM generator.
`timescale 1ns/1ps
package servo_pkg;

    localparam int unsigned ANGLE_W      = 16;
    localparam int unsigned FRAME_CYCLES = 2_000_000;
    localparam int unsigned IR_W_DEF     = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT,
        ST_PARK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with a registered expire flag; serves settle waits and IR timeouts.
`timescale 1ns/1ps
module scan_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_d, count_q;
    logic         expired_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            expired_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == '0);
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/servo_scan_ctrl.sv
// Sweeps the servo, samples IR at each step and parks at the strongest reading.
// Define SERVO_SCAN_AVG_EN to average four IR samples per step.
`timescale 1ns/1ps
module servo_scan_ctrl
    import servo_pkg::*;
#(
    parameter logic [ANGLE_W-1:0] MIN_ANGLE     = 16'd0,
    parameter logic [ANGLE_W-1:0] MAX_ANGLE     = 16'd180,
    parameter logic [ANGLE_W-1:0] STEP          = 16'd10,
    parameter int unsigned        SETTLE_CYCLES = FRAME_CYCLES,
    parameter int unsigned        IR_TIMEOUT    = 1024,
    parameter int unsigned        IR_W          = IR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               ir_req,
    input  logic               ir_valid,
    input  logic [IR_W-1:0]    ir_level,
    output logic [ANGLE_W-1:0] angle,
    output logic               busy,
    output logic               done,
    output logic [ANGLE_W-1:0] best_angle,
    output logic [IR_W-1:0]    best_level,
    output logic               ir_err
);

    localparam int unsigned TMR_MAX  = (SETTLE_CYCLES > IR_TIMEOUT) ? SETTLE_CYCLES : IR_TIMEOUT;
    localparam int unsigned CNT_W    = $clog2(TMR_MAX + 1);
    localparam int unsigned ANGLE_XW = ANGLE_W + 1;
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(IR_TIMEOUT - 1);

    state_e               state_d, state_q;
    logic [ANGLE_W-1:0]   angle_d, angle_q;
    logic [ANGLE_W-1:0]   step_d, step_q;
    logic [ANGLE_W-1:0]   run_angle_d, run_angle_q;
    logic [IR_W-1:0]      run_level_d, run_level_q;
    logic [IR_W-1:0]      sample_d, sample_q;
    logic [ANGLE_W-1:0]   best_angle_d, best_angle_q;
    logic [IR_W-1:0]      best_level_d, best_level_q;
    logic                 ir_req_d, ir_req_q;
    logic                 busy_d, busy_q;
    logic                 done_d, done_q;
    logic                 ir_err_d, ir_err_q;
    logic                 tmr_load_c;
    logic [CNT_W-1:0]     tmr_val_c;
    logic                 tmr_expired;
`ifdef SERVO_SCAN_AVG_EN
    localparam int unsigned SUM_W = IR_W + 2;
    logic [SUM_W-1:0]     sum_d, sum_q;
    logic [1:0]           cnt_d, cnt_q;
`endif

    scan_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .expired  (tmr_expired)
    );

    // Next-state and registered-output logic; abort overrides every transition.
    always_comb begin
        state_d      = state_q;
        angle_d      = angle_q;
        step_d       = step_q;
        run_angle_d  = run_angle_q;
        run_level_d  = run_level_q;
        sample_d     = sample_q;
        best_angle_d = best_angle_q;
        best_level_d = best_level_q;
        ir_req_d     = 1'b0;
        ir_err_d     = ir_err_q;
        tmr_load_c   = 1'b0;
        tmr_val_c    = '0;
`ifdef SERVO_SCAN_AVG_EN
        sum_d        = sum_q;
        cnt_d        = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ir_err_d    = 1'b0;
                    run_level_d = '0;
                    run_angle_d = MIN_ANGLE;
                    step_d      = MIN_ANGLE;
                    state_d     = ST_MOVE;
                end
            end
            ST_MOVE: begin
                angle_d    = step_q;
                tmr_load_c = 1'b1;
                tmr_val_c  = SETTLE_LD;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_expired) begin
                    ir_req_d   = 1'b1;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TIMEOUT_LD;
`ifdef SERVO_SCAN_AVG_EN
                    sum_d      = '0;
                    cnt_d      = '0;
`endif
                    state_d    = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                ir_req_d = 1'b1;
                if (ir_valid || tmr_expired) begin
                    if (!ir_valid) begin
                        ir_err_d = 1'b1;
                    end
`ifdef SERVO_SCAN_AVG_EN
                    sum_d      = sum_q + SUM_W'(ir_valid ? ir_level : '0);
                    cnt_d      = cnt_q + 2'd1;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TIMEOUT_LD;
                    if (cnt_q == 2'd3) begin
                        sample_d = IR_W'(sum_d >> 2);
                        ir_req_d = 1'b0;
                        state_d  = ST_NEXT;
                    end
`else
                    sample_d = ir_valid ? ir_level : '0;
                    ir_req_d = 1'b0;
                    state_d  = ST_NEXT;
`endif
                end
            end
            ST_NEXT: begin
                // Strict compare keeps the lowest angle on ties.
                if (sample_q > run_level_q) begin
                    run_level_d = sample_q;
                    run_angle_d = step_q;
                end
                if ((ANGLE_XW'(step_q) + ANGLE_XW'(STEP)) > ANGLE_XW'(MAX_ANGLE)) begin
                    angle_d    = run_angle_d;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = SETTLE_LD;
                    state_d    = ST_PARK;
                end else begin
                    step_d  = step_q + STEP;
                    state_d = ST_MOVE;
                end
            end
            ST_PARK: begin
                if (tmr_expired) begin
                    best_angle_d = run_angle_q;
                    best_level_d = run_level_q;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            ir_req_d     = 1'b0;
            angle_d      = angle_q;
            best_angle_d = best_angle_q;
            best_level_d = best_level_q;
            ir_err_d     = ir_err_q;
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            angle_q      <= MIN_ANGLE;
            step_q       <= MIN_ANGLE;
            run_angle_q  <= MIN_ANGLE;
            run_level_q  <= '0;
            sample_q     <= '0;
            best_angle_q <= MIN_ANGLE;
            best_level_q <= '0;
            ir_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ir_err_q     <= 1'b0;
`ifdef SERVO_SCAN_AVG_EN
            sum_q        <= '0;
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            step_q       <= step_d;
            run_angle_q  <= run_angle_d;
            run_level_q  <= run_level_d;
            sample_q     <= sample_d;
            best_angle_q <= best_angle_d;
            best_level_q <= best_level_d;
            ir_req_q     <= ir_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ir_err_q     <= ir_err_d;
`ifdef SERVO_SCAN_AVG_EN
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign ir_req     = ir_req_q;
    assign angle      = angle_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_angle = best_angle_q;
    assign best_level = best_level_q;
    assign ir_err     = ir_err_q;

endmodule

// File: tb/tb_servo_scan_ctrl.sv
// Scoreboard bench for servo_scan_ctrl: expected sweep results are queued at start, checked on done.
`timescale 1ns/1ps
module tb_servo_scan_ctrl;

    localparam int unsigned IRW = 12;
`ifdef SERVO_SCAN_AVG_EN
    localparam int NS = 4;
`else
    localparam int NS = 1;
`endif

    typedef struct {
        int ba;
        int bl;
        int ang;
        int err;
        int hs;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic           ir_req;
    logic           ir_valid;
    logic [IRW-1:0] ir_level;
    logic [15:0]    angle;
    logic           busy;
    logic           done;
    logic [15:0]    best_angle;
    logic [IRW-1:0] best_level;
    logic           ir_err;

    int   n_chk;
    int   n_err;
    int   mode;
    int   done_cnt;
    exp_t exp_q[$];

    servo_scan_ctrl #(
        .SETTLE_CYCLES (8),
        .IR_TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .ir_req     (ir_req),
        .ir_valid   (ir_valid),
        .ir_level   (ir_level),
        .angle      (angle),
        .busy       (busy),
        .done       (done),
        .best_angle (best_angle),
        .best_level (best_level),
        .ir_err     (ir_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Hand-chosen IR scenes per test mode
    function automatic int lvl(input int m, input int a, input int idx);
        case (m)
            1: return (a == 60) ? 900 : 100;
            2: return (a == 30 || a == 120) ? 500 : 0;
            3: return (a == 150) ? 300 : 100;
            6: begin
                if (a != 60) return 10;
                case (idx)
                    0: return 100;
                    1: return 200;
                    2: return 300;
                    default: return 401;
                endcase
            end
            default: return 0;
        endcase
    endfunction

    // IR sensor model: answers each request after two cycles, silent at 90 in mode 3
    int dly;
    int idx;
    initial begin
        dly = 0;
        idx = 0;
        ir_valid = 1'b0;
        ir_level = '0;
        forever begin
            @(posedge clk); #1;
            if (ir_valid) begin
                ir_valid = 1'b0;
                dly = 0;
                idx++;
            end else if (ir_req && !(mode == 3 && angle == 16'd90)) begin
                if (dly == 2) begin
                    ir_valid = 1'b1;
                    ir_level = IRW'(lvl(mode, int'(angle), idx));
                end else begin
                    dly++;
                end
            end
            if (!ir_req) begin
                idx = 0;
                dly = 0;
            end
        end
    end

    // Monitor: handshake count, timeout length, and scoreboard pop on done
    int   hs_total;
    int   hs_mark;
    int   run_len;
    logic req_prev;
    logic busy_prev;
    exp_t e;
    initial begin
        hs_total = 0; hs_mark = 0; run_len = 0; done_cnt = 0;
        req_prev = 1'b0; busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 1'b0; busy_prev = 1'b0; run_len = 0;
            end else begin
                if (ir_req && ir_valid) hs_total++;
                if (busy && !busy_prev) hs_mark = hs_total;
                if (ir_req) begin
                    run_len++;
                end else if (req_prev) begin
                    if (mode == 3 && angle == 16'd90) chk("timeout_req_len", run_len, 16 * NS);
                    run_len = 0;
                end
                if (done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_done: got done with best_angle %0d, expected none", best_angle);
                    end else begin
                        e = exp_q.pop_front();
                        chk("best_angle", int'(best_angle), e.ba);
                        chk("best_level", int'(best_level), e.bl);
                        chk("parked_angle", int'(angle), e.ang);
                        chk("ir_err_at_done", int'(ir_err), e.err);
                        chk("handshakes", hs_total - hs_mark, e.hs);
                    end
                end
                req_prev = ir_req;
                busy_prev = busy;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit kick);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done", n);
        end else if (kick) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int n;
        n_chk = 0; n_err = 0;
        start = 1'b0; abort = 1'b0; rst_n = 1'b0; mode = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_angle", int'(angle), 0);
        chk("rst_best_angle", int'(best_angle), 0);
        chk("rst_best_level", int'(best_level), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ir_req", int'(ir_req), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ir_err", int'(ir_err), 0);

        // Peak at 60
        mode = 1;
        exp_q.push_back('{60, 900, 60, 0, 19 * NS});
        pulse_start();
        lat = 1;
        while (!ir_req && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("start_to_req", lat, 10);
        wait_done(1'b0);

        // Tie at 30 and 120 keeps the lower angle
        repeat (5) @(posedge clk);
        #1 mode = 2;
        exp_q.push_back('{30, 500, 30, 0, 19 * NS});
        pulse_start();
        wait_done(1'b0);

        // Silent sensor at 90
        repeat (5) @(posedge clk);
        #1 mode = 3;
        exp_q.push_back('{150, 300, 150, 1, 18 * NS});
        pulse_start();
        wait_done(1'b0);
        repeat (3) @(posedge clk);
        #1 chk("ir_err_sticky", int'(ir_err), 1);

        // Abort during settle at 40
        mode = 1;
        pulse_start();
        chk("ir_err_cleared", int'(ir_err), 0);
        n = 0;
        while (angle != 16'd40 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_40", int'(angle), 40);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_ir_req", int'(ir_req), 0);
        chk("abort_angle", int'(angle), 40);
        chk("abort_best_angle", int'(best_angle), 150);
        chk("abort_best_level", int'(best_level), 300);
        repeat (60) @(posedge clk);
        #1 chk("abort_stays_idle", int'(busy), 0);

        // Starts mid-sweep and in the done cycle are ignored
        exp_q.push_back('{60, 900, 60, 0, 19 * NS});
        pulse_start();
        repeat (30) @(posedge clk);
        pulse_start();
        wait_done(1'b1);
        repeat (30) @(posedge clk);
        #1 chk("no_restart_busy", int'(busy), 0);
        chk("done_count", done_cnt, 4);

`ifdef SERVO_SCAN_AVG_EN
        // Four-sample averaging: 100,200,300,401 -> 250
        mode = 6;
        exp_q.push_back('{60, 250, 60, 0, 76});
        pulse_start();
        wait_done(1'b0);
        repeat (5) @(posedge clk);
        #1;
`endif

        // Reset mid-sweep returns reset values without done
        mode = 1;
        pulse_start();
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_angle", int'(angle), 0);
        chk("mid_rst_best_angle", int'(best_angle), 0);
        chk("mid_rst_best_level", int'(best_level), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ir_req", int'(ir_req), 0);
        chk("mid_rst_done", int'(done), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 chk("leftover_expected", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
